// File: rtl/pipe_pack_pkg.sv
// pipe_pack_pkg: shared FSM state type, header field layout and default widths for pipe_word_packer
package pipe_pack_pkg;
  localparam int DEF_MAX_WORDS = 4;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_PIPE_W = 128;
  localparam int HDR_ID_LSB = 16;
  localparam int HDR_LEN_W = 16;
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
endpackage

// File: rtl/pipe_word_packer_if.sv
// pipe_word_packer_if: host word handshake (word_ena/word_v/word_rdy) and pipe message handshake (pipe_ena/pipe_v/pipe_rdy); master = host+sink, slave = packer
interface pipe_word_packer_if import pipe_pack_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W,
  parameter int PIPE_W = DEF_PIPE_W
);
  logic word_ena, word_rdy, pipe_ena, pipe_rdy;
  logic [WORD_W-1:0] word_v;
  logic [PIPE_W-1:0] pipe_v;
  modport master(output word_ena, word_v, pipe_rdy, input word_rdy, pipe_ena, pipe_v);
  modport slave(input word_ena, word_v, pipe_rdy, output word_rdy, pipe_ena, pipe_v);
endinterface

// File: rtl/pipe_pack_obuf.sv
// pipe_pack_obuf: one-entry output holding register; in clk rst load din pipe_rdy, out pipe_ena pipe_v free (empty or draining this cycle)
module pipe_pack_obuf import pipe_pack_pkg::*; #(
  parameter int PIPE_W = DEF_PIPE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              pipe_rdy,
  input  logic [PIPE_W-1:0] din,
  output logic              pipe_ena,
  output logic              free,
  output logic [PIPE_W-1:0] pipe_v
);
  logic valid;
  always_comb begin
    pipe_ena = valid && pipe_rdy && !rst;
    free = !valid || pipe_ena;
  end
  always_ff @(posedge clk)
    if (rst) begin
      valid <= 1'b0;
      pipe_v <= '0;
    end else begin
      valid <= load || (valid && !pipe_ena);
      if (load) pipe_v <= din;
    end
endmodule

// File: rtl/pipe_word_packer.sv
// pipe_word_packer: packs header+args host words into one pipe message; ports CLK, nRST (sync active-high), bus (slave), err (sticky bad length); `PIPE_PACK_STATS_EN adds msg_count, len_err_count
module pipe_word_packer import pipe_pack_pkg::*; #(
  parameter int MAX_WORDS = DEF_MAX_WORDS,
  parameter int WORD_W = DEF_WORD_W,
  parameter int PIPE_W = DEF_PIPE_W
) (
  input  logic CLK,
  input  logic nRST,
  pipe_word_packer_if.slave bus,
  output logic err
`ifdef PIPE_PACK_STATS_EN
  ,
  output logic [31:0] msg_count,
  output logic [15:0] len_err_count
`else
`endif
);
  localparam int IDX_W = $clog2(MAX_WORDS);
  localparam int LEN_W = $clog2(MAX_WORDS + 1);
  state_t state, state_n;
  logic [MAX_WORDS-1:0][WORD_W-1:0] asm_q, asm_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [LEN_W-1:0] len, len_n;
  logic [HDR_LEN_W-1:0] hlen;
  logic acc, bad, done, load, free;
  assign hlen = bus.word_v[HDR_LEN_W-1:0];
  assign bus.word_rdy = !nRST && state != DONE;
  always_comb begin
    state_n = state;
    asm_n = asm_q;
    idx_n = idx;
    len_n = len;
    acc = bus.word_ena && bus.word_rdy;
    bad = 1'b0;
    done = state == DONE;
    if (acc && state == IDLE) begin
      bad = hlen == '0 || hlen > HDR_LEN_W'(MAX_WORDS);
      asm_n = '0;
      asm_n[0] = bus.word_v;
      len_n = hlen == '0 ? LEN_W'(1) : bad ? LEN_W'(MAX_WORDS) : LEN_W'(hlen);
      idx_n = IDX_W'(1);
      done = len_n == LEN_W'(1);
    end else if (acc && state == FILL) begin
      asm_n[idx] = bus.word_v;
      idx_n = idx + IDX_W'(1);
      done = LEN_W'(idx) + LEN_W'(1) == len;
    end
    // completing word and a free obuf load on the same edge, so DONE is only held while stalled
    load = done && free;
    state_n = load ? IDLE : done ? DONE : acc ? FILL : state;
  end
  always_ff @(posedge CLK)
    if (nRST) begin
      state <= IDLE;
      asm_q <= '0;
      idx <= '0;
      len <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      asm_q <= asm_n;
      idx <= idx_n;
      len <= len_n;
      err <= err || bad;
    end
  pipe_pack_obuf #(.PIPE_W(PIPE_W)) u_obuf (
    .clk(CLK),
    .rst(nRST),
    .load(load),
    .pipe_rdy(bus.pipe_rdy),
    .din(asm_n),
    .pipe_ena(bus.pipe_ena),
    .free(free),
    .pipe_v(bus.pipe_v)
  );
`ifdef PIPE_PACK_STATS_EN
  always_ff @(posedge CLK)
    if (nRST) begin
      msg_count <= '0;
      len_err_count <= '0;
    end else begin
      if (bus.pipe_ena) msg_count <= msg_count + 32'd1;
      if (bad && len_err_count != 16'hFFFF) len_err_count <= len_err_count + 16'd1;
    end
`else
`endif
endmodule

// File: tb/tb_pipe_word_packer.sv
// tb_pipe_word_packer: table vectors, hand-written stall/reset sequences and randomized messages against a queue-based model
module tb_pipe_word_packer;
  logic CLK = 1'b0;
  logic nRST = 1'b1;
  logic err;
  pipe_word_packer_if bus();
`ifdef PIPE_PACK_STATS_EN
  logic [31:0] msg_count;
  logic [15:0] len_err_count;
`endif
  pipe_word_packer dut (
    .CLK(CLK),
    .nRST(nRST),
    .bus(bus),
    .err(err)
`ifdef PIPE_PACK_STATS_EN
    ,
    .msg_count(msg_count),
    .len_err_count(len_err_count)
`endif
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic [3:0][31:0] w;
    int n;
    logic [127:0] v;
    logic e;
  } vec_t;
  vec_t tv[6];
  int n_chk = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, stalls = 0, beats = 0, bad_hdrs = 0;
  bit m_err = 1'b0, rand_rdy = 1'b0;
  logic [127:0] got_q[$], exp_q[$];
  int got_cyc[$];
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK)
    if (bus.pipe_ena) begin
      got_q.push_back(bus.pipe_v);
      got_cyc.push_back(cyc);
      beats++;
    end
  always @(posedge CLK)
    if (rand_rdy) begin
      #1;
      if (rand_rdy) bus.pipe_rdy = 1'($urandom_range(0, 1));
    end
  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send(logic [31:0] w);
    int t = 0;
    @(negedge CLK);
    while (!bus.word_rdy && t < 100) begin
      stalls++;
      t++;
      @(negedge CLK);
    end
    if (!bus.word_rdy) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: word_rdy stayed 0 for word %h", w);
    end else begin
      bus.word_ena = 1'b1;
      bus.word_v = w;
      @(posedge CLK);
      #1;
      bus.word_ena = 1'b0;
      acc_cyc = cyc;
    end
  endtask
  task automatic wait_beats(int n, int lim);
    int t = 0;
    while (got_q.size() < n && t < lim) begin
      t++;
      @(posedge CLK);
    end
    #1;
    if (got_q.size() < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL beat_timeout: got %0d messages expected %0d", got_q.size(), n);
    end
  endtask
  function automatic int eff_len(logic [31:0] h);
    int l = int'(h[15:0]);
    return l == 0 ? 1 : (l > 4 ? 4 : l);
  endfunction
  task automatic send_rand();
    logic [3:0][31:0] w;
    logic [127:0] v = '0;
    int n;
    w[0] = {16'($urandom), 16'($urandom_range(0, 6))};
    for (int k = 1; k < 4; k++) w[k] = $urandom;
    n = eff_len(w[0]);
    for (int k = 0; k < n; k++) v[32*k +: 32] = w[k];
    if (w[0][15:0] == 16'd0 || w[0][15:0] > 16'd4) begin
      m_err = 1'b1;
      bad_hdrs++;
    end
    exp_q.push_back(v);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) @(posedge CLK);
      send(w[k]);
    end
  endtask
  task automatic clear_q();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask
  initial begin
    tv[0] = '{{32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'h0003_0001}, 1, {96'h0, 32'h0003_0001}, 1'b0};
    tv[1] = '{{32'hC, 32'hB, 32'hA, 32'h0001_0004}, 4, {32'hC, 32'hB, 32'hA, 32'h0001_0004}, 1'b0};
    tv[2] = '{{32'hDEAD0003, 32'hDEAD0002, 32'h1234, 32'h0005_0002}, 2, {64'h0, 32'h1234, 32'h0005_0002}, 1'b0};
    tv[3] = '{{32'hDEAD0003, 32'h2, 32'h1, 32'h0007_0003}, 3, {32'h0, 32'h2, 32'h1, 32'h0007_0003}, 1'b0};
    tv[4] = '{{32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'h0002_0000}, 1, {96'h0, 32'h0002_0000}, 1'b1};
    tv[5] = '{{32'h3, 32'h2, 32'h1, 32'h0002_0009}, 4, {32'h3, 32'h2, 32'h1, 32'h0002_0009}, 1'b1};
    bus.word_ena = 1'b0;
    bus.word_v = '0;
    bus.pipe_rdy = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset_word_rdy", 128'(bus.word_rdy), 128'd0);
    check("reset_pipe_ena", 128'(bus.pipe_ena), 128'd0);
    nRST = 1'b0;
    @(negedge CLK);
    check("reset_pipe_v", bus.pipe_v, 128'd0);
    check("reset_err", 128'(err), 128'd0);
    check("idle_word_rdy", 128'(bus.word_rdy), 128'd1);
    check("idle_pipe_ena", 128'(bus.pipe_ena), 128'd0);
    for (int i = 0; i < 6; i++) begin
      stalls = 0;
      clear_q();
      for (int k = 0; k < tv[i].n; k++) send(tv[i].w[k]);
      wait_beats(1, 20);
      if (got_q.size() > 0) begin
        check($sformatf("vec%0d_v", i), got_q[0], tv[i].v);
        check($sformatf("vec%0d_latency", i), 128'(got_cyc[0]), 128'(acc_cyc));
      end
      check($sformatf("vec%0d_err", i), 128'(err), 128'(tv[i].e));
      check($sformatf("vec%0d_no_stall", i), 128'(stalls), 128'd0);
      check($sformatf("vec%0d_one_msg", i), 128'(got_q.size()), 128'd1);
    end
    clear_q();
    bus.pipe_rdy = 1'b0;
    send(32'h0011_0002);
    send(32'hAA);
    send(32'h0012_0002);
    send(32'hBB);
    @(negedge CLK);
    check("stall_word_rdy", 128'(bus.word_rdy), 128'd0);
    check("stall_no_beat", 128'(got_q.size()), 128'd0);
    @(posedge CLK);
    #1;
    bus.pipe_rdy = 1'b1;
    wait_beats(2, 20);
    if (got_q.size() >= 2) begin
      check("stall_first", got_q[0], {64'h0, 32'hAA, 32'h0011_0002});
      check("stall_second", got_q[1], {64'h0, 32'hBB, 32'h0012_0002});
      check("stall_consecutive", 128'(got_cyc[1] - got_cyc[0]), 128'd1);
    end
    clear_q();
    send(32'h0021_0004);
    send(32'h1);
    send(32'h2);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    nRST = 1'b0;
    m_err = 1'b0;
    beats = 0;
    bad_hdrs = 0;
    repeat (3) @(negedge CLK);
    check("midreset_no_beat", 128'(got_q.size()), 128'd0);
    check("midreset_err", 128'(err), 128'd0);
    send(32'h0022_0002);
    send(32'h5);
    wait_beats(1, 20);
    if (got_q.size() > 0) check("midreset_next", got_q[0], {64'h0, 32'h5, 32'h0022_0002});
    check("midreset_one_msg", 128'(got_q.size()), 128'd1);
`ifdef PIPE_PACK_STATS_EN
    check("stats_msg_count_1", 128'(msg_count), 128'(beats));
    check("stats_len_err_0", 128'(len_err_count), 128'd0);
`endif
    clear_q();
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) send_rand();
    rand_rdy = 1'b0;
    @(posedge CLK);
    #2;
    bus.pipe_rdy = 1'b1;
    wait_beats(exp_q.size(), 400);
    check("rand_count", 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check($sformatf("rand_msg%0d", i), got_q[i], exp_q[i]);
    check("rand_err", 128'(err), 128'(m_err));
`ifdef PIPE_PACK_STATS_EN
    check("stats_msg_count", 128'(msg_count), 128'(beats));
    check("stats_len_err", 128'(len_err_count), 128'(bad_hdrs));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
